// File: rtl/a23_out_streamer_if.sv
// Bundle between a23_gc_main's result port, the result streamer and the host-side unloader.
// Stream handshake: a word transfers on every rising edge where word_valid && word_ready;
// once raised, word_valid stays high and word_data/word_idx/word_last stay stable until that transfer.
interface a23_out_streamer_if #(
    parameter int OUT_MEM_SIZE = 64,
    parameter int IDX_W        = 6,
    parameter int CYCLE_W      = 32
);
    logic [OUT_MEM_SIZE*32-1:0] o;
    logic                       terminate;
    logic [31:0]                word_data;
    logic [IDX_W-1:0]           word_idx;
    logic                       word_valid;
    logic                       word_ready;
    logic                       word_last;
    logic [CYCLE_W-1:0]         cycle_count;
    logic                       done;

    modport master (
        input  o, terminate, word_ready,
        output word_data, word_idx, word_valid, word_last, cycle_count, done
    );

    modport slave (
        output o, terminate, word_ready,
        input  word_data, word_idx, word_valid, word_last, cycle_count, done
    );
endinterface

// File: rtl/a23_out_streamer.sv
// Counts core run cycles, snapshots the output memory on terminate and drains it
// one 32-bit word per handshake; every output comes straight from a flop.
module a23_out_streamer #(
    parameter int OUT_MEM_SIZE = 64,
    parameter int IDX_W        = 6,
    parameter int CYCLE_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    a23_out_streamer_if.master   bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);

    state_t             state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   idx_nxt;
    logic [31:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic [31:0]        snap_q [OUT_MEM_SIZE];
    logic [31:0]        snap_d [OUT_MEM_SIZE];

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = done_q;
        snap_d  = snap_q;
        idx_nxt = idx_q + IDX_W'(1);
        case (state_q)
            S_RUN: begin
                if (bus.terminate) begin
                    for (int i = 0; i < OUT_MEM_SIZE; i++) begin
                        snap_d[i] = bus.o[32*i +: 32];
                    end
                    idx_d   = '0;
                    data_d  = bus.o[31:0];
                    valid_d = 1'b1;
                    last_d  = (LAST_IDX == '0);
                    state_d = S_STREAM;
                end else if (cycle_q != '1) begin
                    cycle_d = cycle_q + CYCLE_W'(1);
                end
            end
            S_STREAM: begin
                // valid_q is always high here, so ready alone marks a transfer
                if (bus.word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_nxt;
                        data_d = snap_q[idx_nxt];
                        last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cycle_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Snapshot contents are meaningless after reset, so it carries no reset term
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign bus.word_data   = data_q;
    assign bus.word_idx    = idx_q;
    assign bus.word_valid  = valid_q;
    assign bus.word_last   = last_q;
    assign bus.cycle_count = cycle_q;
    assign bus.done        = done_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_a23_out_streamer.sv
// Directed bench for a23_out_streamer: a full-width instance plus a 4-bit cycle counter instance.
module tb_a23_out_streamer;
  localparam int N = 64;

  typedef struct {
    logic        rst;
    logic        term;
    logic        rdy;
    logic        exp_valid;
    logic [5:0]  exp_idx;
    logic        exp_last;
    logic        exp_done;
    logic [31:0] exp_cnt;
    logic [31:0] exp_data;
  } vec_t;

  logic clk;
  logic rst;
  logic term;
  logic rdy;
  logic [N*32-1:0] o_tb;
  logic [1:0] dbg1, dbg2;
  logic [31:0] exp_w [N];
  logic [31:0] exp_q [$];
  int n_chk;
  int n_pass;
  vec_t vecs [9];

  a23_out_streamer_if #(.OUT_MEM_SIZE(N), .IDX_W(6), .CYCLE_W(32)) bus1 ();
  a23_out_streamer_if #(.OUT_MEM_SIZE(N), .IDX_W(6), .CYCLE_W(4))  bus2 ();

  assign bus1.o = o_tb;
  assign bus2.o = o_tb;
  assign bus1.terminate = term;
  assign bus2.terminate = term;
  assign bus1.word_ready = rdy;
  assign bus2.word_ready = rdy;

  a23_out_streamer #(.OUT_MEM_SIZE(N), .IDX_W(6), .CYCLE_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1)
  );
  a23_out_streamer #(.OUT_MEM_SIZE(N), .IDX_W(6), .CYCLE_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic set_o(input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < N; i++) begin
      exp_w[i] = base + stride * 32'(i);
      o_tb[32*i +: 32] = exp_w[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    term = 1'b0;
    rdy = 1'b0;
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic r, input logic t, input logic y, input logic v,
                              input logic [5:0] i, input logic l, input logic d,
                              input logic [31:0] c, input logic [31:0] dt);
    vec_t x;
    x.rst = r; x.term = t; x.rdy = y; x.exp_valid = v; x.exp_idx = i;
    x.exp_last = l; x.exp_done = d; x.exp_cnt = c; x.exp_data = dt;
    return x;
  endfunction

  // driver + scoreboard for one full drain; mode 0 = ready held high, 1 = random ready
  task automatic drain(input int mode, input bit toggle, input bit chk2);
    int n_hs;
    int cyc;
    int last_hs_cyc;
    bit stalled;
    logic [38:0] prev;
    logic [31:0] e;
    n_hs = 0;
    cyc = 0;
    last_hs_cyc = 0;
    stalled = 1'b0;
    prev = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_w[i]);
    while (n_hs < N && cyc < 2000) begin
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (toggle) term = ~term;
      if (stalled)
        chk("hold", 64'({bus1.word_valid, bus1.word_idx, bus1.word_data}), 64'(prev));
      if (bus1.word_valid && rdy) begin
        e = exp_q.pop_front();
        chk("hs_idx", 64'(bus1.word_idx), 64'(n_hs));
        chk("hs_data", 64'(bus1.word_data), 64'(e));
        chk("hs_last", 64'(bus1.word_last), 64'(n_hs == N - 1));
        if (chk2) begin
          chk("hs2_idx", 64'(bus2.word_idx), 64'(n_hs));
          chk("hs2_data", 64'(bus2.word_data), 64'(e));
        end
        n_hs++;
        last_hs_cyc = cyc + 1;
      end
      stalled = bus1.word_valid && !rdy;
      prev = {bus1.word_valid, bus1.word_idx, bus1.word_data};
      step();
      cyc++;
    end
    rdy = 1'b0;
    chk("transfers", 64'(n_hs), 64'(N));
    chk("done_after_last", 64'(bus1.done), 64'd1);
    chk("valid_after_last", 64'(bus1.word_valid), 64'd0);
    if (mode == 0) chk("stream_cycles", 64'(last_hs_cyc), 64'(N));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    term = 1'b0;
    rdy = 1'b0;
    o_tb = '0;

    // 1: basic drain, terminate on the 10th edge after release
    set_o(32'h1000_0000, 32'd1);
    do_reset();
    chk("rst_state", 64'({bus1.word_valid, bus1.word_last, bus1.done, bus1.word_idx}), 64'd0);
    chk("rst_data", 64'(bus1.word_data), 64'd0);
    chk("rst_cnt", 64'(bus1.cycle_count), 64'd0);
    repeat (9) step();
    chk("run_no_valid", 64'(bus1.word_valid), 64'd0);
    term = 1'b1;
    step();
    term = 1'b0;
    chk("t1_cnt", 64'(bus1.cycle_count), 64'd9);
    chk("t1_first", 64'({bus1.word_valid, bus1.word_idx, bus1.word_data}), 64'({1'b1, 6'd0, 32'h1000_0000}));
    drain(0, 1'b0, 1'b0);
    chk("t1_cnt_end", 64'(bus1.cycle_count), 64'd9);

    // 2+3: backpressure with o and terminate disturbed after capture
    set_o(32'hC0DE_0000, 32'h0001_0101);
    do_reset();
    repeat (3) step();
    term = 1'b1;
    step();
    o_tb = '1;
    chk("t2_cnt", 64'(bus1.cycle_count), 64'd3);
    drain(1, 1'b1, 1'b0);
    chk("t3_cnt", 64'(bus1.cycle_count), 64'd3);
    repeat (4) begin
      term = ~term;
      step();
    end
    chk("t3_done_hold", 64'({bus1.done, bus1.word_valid}), 64'({1'b1, 1'b0}));
    chk("t3_cnt_hold", 64'(bus1.cycle_count), 64'd3);

    // 4: reset right after word 20 is accepted
    set_o(32'h5A5A_0000, 32'd7);
    do_reset();
    term = 1'b1;
    step();
    term = 1'b0;
    rdy = 1'b1;
    repeat (21) step();
    chk("t4_idx21", 64'(bus1.word_idx), 64'd21);
    rst = 1'b1;
    rdy = 1'b0;
    step();
    rst = 1'b0;
    chk("t4_after_rst", 64'({bus1.word_valid, bus1.done, bus1.word_idx}), 64'd0);
    chk("t4_cnt_rst", 64'(bus1.cycle_count), 64'd0);
    repeat (5) step();
    term = 1'b1;
    step();
    term = 1'b0;
    chk("t4_cnt5", 64'(bus1.cycle_count), 64'd5);
    drain(1, 1'b0, 1'b0);

    // 5: table of per-edge vectors, immediate terminate and a short reset/restart
    set_o(32'h1000_0000, 32'd1);
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd0, 32'h1000_0000);
    vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 1'b0, 32'd0, 32'h1000_0001);
    vecs[3] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 32'd0, 32'h1000_0001);
    vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 32'd0, 32'h1000_0002);
    vecs[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'h0);
    vecs[6] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'd1, 32'h0);
    vecs[7] = mk(1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'd2, 32'h0);
    vecs[8] = mk(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 32'd2, 32'h1000_0000);
    for (int v = 0; v < 9; v++) begin
      rst = vecs[v].rst;
      term = vecs[v].term;
      rdy = vecs[v].rdy;
      step();
      chk($sformatf("vec%0d_ctl", v),
          64'({bus1.word_valid, bus1.word_idx, bus1.word_last, bus1.done}),
          64'({vecs[v].exp_valid, vecs[v].exp_idx, vecs[v].exp_last, vecs[v].exp_done}));
      chk($sformatf("vec%0d_cnt", v), 64'(bus1.cycle_count), 64'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d_data", v), 64'(bus1.word_data), 64'(vecs[v].exp_data));
    end
    rst = 1'b0;
    term = 1'b0;
    rdy = 1'b0;

    // 6: 4-bit counter saturates after 20 idle cycles
    set_o(32'h0BAD_F00D, 32'h0000_1001);
    do_reset();
    repeat (20) step();
    term = 1'b1;
    step();
    term = 1'b0;
    chk("t6_cnt32", 64'(bus1.cycle_count), 64'd20);
    chk("t6_cnt4", 64'(bus2.cycle_count), 64'hF);
    drain(0, 1'b0, 1'b1);
    chk("t6_done4", 64'({bus2.done, bus2.word_valid}), 64'({1'b1, 1'b0}));
    chk("t6_cnt4_end", 64'(bus2.cycle_count), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/a23_out_streamer.md
Name: a23_out_streamer

Overview:
- Sits directly downstream of a23_gc_main and consumes its flat output memory bus `o` and its `terminate` flag.
- While the core runs, it counts clock cycles. On `terminate` it snapshots the whole output memory.
- It then streams the snapshot out one 32-bit word at a time over a valid/ready handshake, so a host or garbling-harness unloader can drain results without a wide parallel port.
- It reports the run's cycle count alongside the data.

Parameters:
- OUT_MEM_SIZE, 64: number of 32-bit words in the output memory. Must match the core.
- IDX_W, 6: width of the word index; must satisfy 2^IDX_W >= OUT_MEM_SIZE.
- CYCLE_W, 32: width of the cycle counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- o, input, OUT_MEM_SIZE*32: core output memory; word i occupies bits [32*(i+1)-1 : 32*i].
- terminate, input, 1: core completion flag.
- word_data, output, 32: current streamed word.
- word_idx, output, IDX_W: index of the current word.
- word_valid, output, 1: word_data and word_idx are valid.
- word_ready, input, 1: consumer accepts the word.
- word_last, output, 1: high with word_valid when word_idx == OUT_MEM_SIZE-1.
- cycle_count, output, CYCLE_W: cycles the core ran before terminate.
- done, output, 1: all words transferred.

Behaviour:
- States: RUN, STREAM, DONE. All outputs are registered or decoded from registered state only; no combinational path from word_ready to any output.
- Reset, on any edge with rst=1, from any state including mid-stream:
  - state goes to RUN.
  - cycle_count, word_idx and done go to 0.
  - word_valid and word_last go to 0.
  - word_data goes to 0.
  - The snapshot is don't-care.
  - rst has priority over every other event on the same edge.
- RUN:
  - On each edge with terminate=0: cycle_count increments, saturating at all-ones (no wrap).
  - On the first edge with terminate=1:
    - snapshot <= o (the whole bus, sampled at that edge).
    - cycle_count holds its value.
    - word_idx <= 0; state goes to STREAM.
    - word_valid rises in the following cycle, with word_data = snapshot word 0.
  - If terminate=1 on the first edge after reset release, cycle_count = 0.
- STREAM:
  - word_valid = 1; word_data = snapshot[word_idx]; word_last = (word_idx == OUT_MEM_SIZE-1).
  - Handshake occurs on an edge with word_valid & word_ready.
    - If word_idx < OUT_MEM_SIZE-1: word_idx increments, and the next word appears the cycle after, giving one word per cycle under continuous ready.
    - If word_idx == OUT_MEM_SIZE-1: state goes to DONE.
  - With word_ready=0: word_data, word_idx and word_last hold stable. Valid never drops before acceptance.
  - terminate and o are ignored after capture; later changes do not affect streamed data.
- DONE:
  - word_valid = 0, word_last = 0, done = 1.
  - cycle_count and the snapshot hold.
  - Stays in DONE until rst; terminate toggling has no effect.
- Throughput and latency:
  - First word_valid is 1 cycle after the terminate capture edge.
  - Total stream with continuous ready is OUT_MEM_SIZE cycles.
  - done rises 1 cycle after the last handshake.
- Widths: cycle_count is unsigned; word_idx is zero-extended into IDX_W.

Test Plan:
1. Basic drain.
   - Stimulus: rst released; terminate asserted on the 10th edge after release; o word i = 32'h1000_0000+i; word_ready held 1.
   - Required response: cycle_count = 9; exactly 64 handshakes with data 0x10000000..0x1000003F in order; word_last only on idx 63; done = 1 one cycle after the last handshake; word_valid = 0 afterwards.
2. Backpressure.
   - Stimulus: word_ready pattern 1,0,0,1,0,1... (pseudo-random).
   - Required response: word_data and word_idx stable while valid & !ready; no skipped or duplicated index; 64 total transfers.
3. Snapshot isolation.
   - Stimulus: after the capture edge, drive o to all 0xFFFFFFFF and toggle terminate.
   - Required response: streamed words still equal the captured values; cycle_count unchanged.
4. Reset mid-stream.
   - Stimulus: assert rst for one cycle right after word 20 is accepted; then rerun with terminate after 5 cycles.
   - Required response: the cycle after rst, word_valid = 0, done = 0, cycle_count = 0; second run streams from idx 0 with cycle_count = 5.
5. Immediate terminate.
   - Stimulus: terminate = 1 already on the first edge after rst deasserts.
   - Required response: cycle_count = 0; word 0 valid on the next cycle.
6. Saturation.
   - Stimulus: CYCLE_W = 4; terminate after 20 idle cycles.
   - Required response: cycle_count = 4'hF; streaming otherwise normal.
